// File: rtl/patching_pkg.sv
// patching_pkg: shared FSM states, cache write constant and default sizes for the patch write-back path
package patching_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} wb_state_t;
    localparam logic CACHE_WRITE = 1'b0;
    localparam int DEF_N = 16;
    localparam int DEF_M = 16;
    localparam int DEF_ADDR_WIDTH = 21;
endpackage

// File: rtl/patch_mask_scan.sv
// patch_mask_scan: combinational lowest-set-bit finder over an M-bit patch mask
module patch_mask_scan #(
    parameter int M = 16
) (
    input  logic [M-1:0]         mask,
    output logic [$clog2(M)-1:0] index,
    output logic                 any_set
);
    localparam int IW = $clog2(M);
    // descending sweep so the lowest set bit is the last one to win
    always_comb begin
        index = '0;
        for (int i = M - 1; i >= 0; i--)
            if (mask[i]) index = IW'(i);
        any_set = |mask;
    end
endmodule

// File: rtl/patch_writeback_16.sv
// patch_writeback_16: writes masked activations back to the cache one word at a time; optional per-word watchdog via PATCH_WB_TIMEOUT_EN
module patch_writeback_16
    import patching_pkg::*;
#(
    parameter int N              = DEF_N,
    parameter int M              = DEF_M,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_address,
    input  logic [M-1:0]             p,
    input  logic [M-1:0][N-1:0]      activation_patched,
    output logic                     busy,
    output logic                     done,
    output logic                     wb_error,
    output logic                     timeout,
    output logic [$clog2(M+1)-1:0]   written_count,
    output logic                     request,
    output logic                     read_write,
    output logic [ADDR_WIDTH-1:0]    address,
    output logic [N-1:0]             activation_in,
    input  logic                     valid,
    input  logic                     error
);
    localparam int IW = $clog2(M);
    localparam int CW = $clog2(M + 1);

    wb_state_t            state;
    logic [M-1:0]         mask_q;
    logic [M-1:0]         mask_clr;
    logic [M-1:0]         scan_in;
    logic [M-1:0][N-1:0]  data_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        scan_idx;
    logic                 scan_any;
    logic                 wb_err_q;
    logic                 to_q;
    logic                 wd_fire;
    logic [CW-1:0]        wc_q;

    // In IDLE the scan looks at the incoming mask; in ISSUE at what remains once the current word retires
    assign mask_clr = mask_q & ~(M'(1) << idx_q);
    assign scan_in  = (state == IDLE) ? p : mask_clr;

    patch_mask_scan #(.M(M)) u_scan (
        .mask    (scan_in),
        .index   (scan_idx),
        .any_set (scan_any)
    );

`ifdef PATCH_WB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q;
    assign wd_fire = state == ISSUE && !valid && !error && wd_q == WW'(TIMEOUT_CYCLES - 1);
    // per-word watchdog: counts unanswered ISSUE cycles, restarts on every response or state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= (state == ISSUE && !valid && !error) ? wd_q + WW'(1) : '0;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_fire = 1'b0;
`endif

    // job FSM: latch on start, retire words in ascending index order, abort on error or watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mask_q   <= '0;
            data_q   <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            wc_q     <= '0;
            wb_err_q <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mask_q   <= p;
                    data_q   <= activation_patched;
                    base_q   <= base_address;
                    idx_q    <= scan_idx;
                    wc_q     <= '0;
                    wb_err_q <= 1'b0;
                    to_q     <= 1'b0;
                    state    <= scan_any ? ISSUE : DONE;
                end
                ISSUE: if (error) begin
                    wb_err_q <= 1'b1;
                    state    <= DONE;
                end else if (valid) begin
                    wc_q   <= wc_q + CW'(1);
                    mask_q <= mask_clr;
                    idx_q  <= scan_idx;
                    state  <= scan_any ? ISSUE : DONE;
                end else if (wd_fire) begin
                    wb_err_q <= 1'b1;
                    to_q     <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign request       = state == ISSUE;
    assign busy          = request;
    assign done          = state == DONE;
    assign read_write    = CACHE_WRITE;
    assign address       = request ? base_q + ADDR_WIDTH'(idx_q) : '0;
    assign activation_in = request ? data_q[idx_q] : '0;
    assign wb_error      = wb_err_q;
    assign timeout       = to_q;
    assign written_count = wc_q;
endmodule

// File: tb/tb_patch_writeback_16.sv
// tb_patch_writeback_16: directed self-checking bench for the patch write-back engine
module tb_patch_writeback_16;
    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [20:0]       base_address;
    logic [15:0]       p;
    logic [15:0][15:0] activation_patched;
    logic              busy, done, wb_error, timeout, request, read_write;
    logic [4:0]        written_count;
    logic [20:0]       address;
    logic [15:0]       activation_in;
    logic              valid, error;

    int checks = 0;
    int errors = 0;

    logic [15:0][15:0] vec;
    logic [20:0] wa[$];
    logic [15:0] wdat[$];
    int          wh[$];
    int done_cyc, req_cycles, unstable, req_in_done;

    patch_writeback_16 dut (
        .clk(clk), .reset(reset), .start(start), .base_address(base_address), .p(p),
        .activation_patched(activation_patched), .busy(busy), .done(done), .wb_error(wb_error),
        .timeout(timeout), .written_count(written_count), .request(request),
        .read_write(read_write), .address(address), .activation_in(activation_in),
        .valid(valid), .error(error)
    );

    always #5 clk = ~clk;

    // lat = request cycles per word before the acknowledge (0 = never answer); err_at = word index answered with error
    task automatic run_job(input logic [15:0] mask, input logic [20:0] base, input int lat,
                           input int err_at, input int budget, input bit mid_start);
        int cyc, h, word;
        logic [20:0] a0;
        logic [15:0] d0;
        cyc = 0; h = 0; word = 0; a0 = '0; d0 = '0;
        wa.delete(); wdat.delete(); wh.delete();
        done_cyc = -1; req_cycles = 0; unstable = 0; req_in_done = 0;
        @(negedge clk);
        p = mask; base_address = base; activation_patched = vec; start = 1'b1;
        while (done_cyc < 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = mid_start && cyc == 1;
            p = 16'hFFFF; base_address = 21'h0; activation_patched = '1;
            valid = 1'b0; error = 1'b0;
            if (done) begin
                done_cyc = cyc;
                req_in_done = int'(request);
            end else if (request) begin
                req_cycles++;
                if (h == 0) begin a0 = address; d0 = activation_in; end
                else if (address !== a0 || activation_in !== d0) unstable++;
                h++;
                if (h == lat) begin
                    if (word == err_at) error = 1'b1;
                    else begin
                        valid = 1'b1;
                        wa.push_back(address); wdat.push_back(activation_in); wh.push_back(h);
                    end
                    word++;
                    h = 0;
                end
            end
        end
        @(negedge clk);
        start = 1'b0; valid = 1'b0; error = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; valid = 1'b0; error = 1'b0;
        p = '0; base_address = '0; activation_patched = '0;
        repeat (2) @(negedge clk);
        checks++; if (request !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl: req/busy/done=%b%b%b expected 000", request, busy, done); end
        checks++; if (wb_error !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: wb_error/timeout=%b%b expected 00", wb_error, timeout); end
        checks++; if (written_count !== 5'd0 || address !== 21'd0 || activation_in !== 16'd0) begin errors++; $display("FAIL reset_data: cnt=%0d addr=%h data=%h expected 0", written_count, address, activation_in); end
        checks++; if (read_write !== 1'b0) begin errors++; $display("FAIL read_write: got %b expected 0", read_write); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        for (int i = 0; i < 16; i++) vec[i] = 16'hA000 + 16'(i);
        vec[0] = 16'hBEEF;
        run_job(16'h0001, 21'h100, 1, -1, 20, 1'b0);
        checks++; if (wa.size() != 1 || wa[0] !== 21'h100 || wdat[0] !== 16'hBEEF) begin errors++; $display("FAIL single_write: n=%0d addr=%h data=%h expected 1 100 beef", wa.size(), wa[0], wdat[0]); end
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL single_done_cycle: got %0d expected 2", done_cyc); end
        checks++; if (written_count !== 5'd1 || wb_error !== 1'b0) begin errors++; $display("FAIL single_status: cnt=%0d err=%b expected 1 0", written_count, wb_error); end
    endtask

    task automatic test_latency;
        logic [20:0] ea [4];
        logic [15:0] ed [4];
        ea = '{21'h2000, 21'h2002, 21'h200D, 21'h200F};
        ed = '{16'hA000, 16'hA002, 16'hA00D, 16'hA00F};
        for (int i = 0; i < 16; i++) vec[i] = 16'hA000 + 16'(i);
        run_job(16'hA005, 21'h2000, 2, -1, 40, 1'b0);
        checks++; if (wa.size() != 4) begin errors++; $display("FAIL lat_words: got %0d expected 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wa[i] !== ea[i] || wdat[i] !== ed[i] || wh[i] != 2) begin errors++; $display("FAIL lat_word%0d: addr=%h data=%h hold=%0d expected %h %h 2", i, wa[i], wdat[i], wh[i], ea[i], ed[i]); end
        end
        checks++; if (written_count !== 5'd4 || wb_error !== 1'b0 || unstable != 0) begin errors++; $display("FAIL lat_status: cnt=%0d err=%b unstable=%0d expected 4 0 0", written_count, wb_error, unstable); end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL lat_done_cycle: got %0d expected 9", done_cyc); end
    endtask

    task automatic test_empty;
        run_job(16'h0000, 21'h55, 1, -1, 20, 1'b0);
        checks++; if (done_cyc != 1 || req_cycles != 0) begin errors++; $display("FAIL empty: done_cyc=%0d req_cycles=%0d expected 1 0", done_cyc, req_cycles); end
        checks++; if (written_count !== 5'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", written_count); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) vec[i] = 16'h5A00 + 16'(i);
        run_job(16'hFFFF, 21'h40, 1, -1, 40, 1'b0);
        checks++; if (req_cycles != 16 || done_cyc != 17) begin errors++; $display("FAIL b2b_timing: req_cycles=%0d done_cyc=%0d expected 16 17", req_cycles, done_cyc); end
        checks++; if (written_count !== 5'd16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", written_count); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (wa[i] !== 21'h40 + 21'(i) || wdat[i] !== 16'h5A00 + 16'(i)) begin errors++; $display("FAIL b2b_word%0d: addr=%h data=%h", i, wa[i], wdat[i]); end
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b one cycle later expected 0", done); end
    endtask

    task automatic test_error;
        run_job(16'hFFFF, 21'h300, 1, 2, 40, 1'b0);
        checks++; if (written_count !== 5'd2 || wa.size() != 2) begin errors++; $display("FAIL err_count: cnt=%0d logged=%0d expected 2 2", written_count, wa.size()); end
        checks++; if (wb_error !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL err_flags: wb_error=%b timeout=%b expected 1 0", wb_error, timeout); end
        checks++; if (done_cyc != 4 || req_in_done != 0) begin errors++; $display("FAIL err_abort: done_cyc=%0d req_in_done=%0d expected 4 0", done_cyc, req_in_done); end
    endtask

    task automatic test_wrap_and_ignore;
        for (int i = 0; i < 16; i++) vec[i] = 16'hC000 + 16'(i);
        run_job(16'h0003, 21'h1FFFFF, 2, -1, 40, 1'b1);
        checks++; if (wa.size() != 2 || wa[0] !== 21'h1FFFFF || wa[1] !== 21'h000000) begin errors++; $display("FAIL wrap_addr: n=%0d a0=%h a1=%h expected 2 1fffff 000000", wa.size(), wa[0], wa[1]); end
        checks++; if (wdat[0] !== 16'hC000 || wdat[1] !== 16'hC001) begin errors++; $display("FAIL wrap_data: d0=%h d1=%h expected c000 c001", wdat[0], wdat[1]); end
        checks++; if (done_cyc != 5 || written_count !== 5'd2 || wb_error !== 1'b0) begin errors++; $display("FAIL wrap_status: done_cyc=%0d cnt=%0d err=%b expected 5 2 0", done_cyc, written_count, wb_error); end
    endtask

    task automatic test_reset_mid_job;
        int dones;
        dones = 0;
        @(negedge clk);
        p = 16'hFFFF; base_address = 21'h10; activation_patched = vec; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (request !== 1'b1) begin errors++; $display("FAIL midrst_pre: request=%b expected 1", request); end
        #2 reset = 1'b1;
        #1;
        checks++; if (request !== 1'b0 || busy !== 1'b0 || address !== 21'd0) begin errors++; $display("FAIL midrst_async: req=%b busy=%b addr=%h expected 0 0 0", request, busy, address); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1 || request === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done: done/request seen %0d times expected 0", dones); end
    endtask

    task automatic test_timeout;
`ifdef PATCH_WB_TIMEOUT_EN
        run_job(16'h0100, 21'h0, 0, -1, 100, 1'b0);
        checks++; if (done_cyc != 65 || req_cycles != 64) begin errors++; $display("FAIL to_timing: done_cyc=%0d req_cycles=%0d expected 65 64", done_cyc, req_cycles); end
        checks++; if (timeout !== 1'b1 || wb_error !== 1'b1 || written_count !== 5'd0) begin errors++; $display("FAIL to_flags: timeout=%b err=%b cnt=%0d expected 1 1 0", timeout, wb_error, written_count); end
`else
        run_job(16'h0100, 21'h0, 0, -1, 80, 1'b0);
        checks++; if (done_cyc != -1 || req_cycles != 80 || timeout !== 1'b0) begin errors++; $display("FAIL no_timeout: done_cyc=%0d req_cycles=%0d timeout=%b expected -1 80 0", done_cyc, req_cycles, timeout); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
    endtask

    initial begin
        test_reset;
        test_single;
        test_latency;
        test_empty;
        test_back_to_back;
        test_error;
        test_wrap_and_ignore;
        test_reset_mid_job;
        test_timeout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
